// File: rtl/expe_sched.sv
// Experiment scheduler: validates requested codes and sequences every select-bus switch
// through a drain (bus forced to 0) and a settle phase so no two enables ever overlap.
//
// state  | meaning
// IDLE   | nothing selected, bus at 0, ready for a request
// DRAIN  | bus held at 0 while previous enable turns off
// SETTLE | new code driven, decoder settling, not yet running
// RUN    | selected experiment active, ready for a new request
module expe_sched #(
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_code,
  input  logic       abort,
  output logic [7:0] select,
  output logic       active,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, SETTLE, RUN} state_t;

  state_t     state, state_nx;
  logic [7:0] pending, pending_nx;
  logic [7:0] count, count_nx;
  logic [7:0] select_nx;
  logic       active_nx, busy_nx, done_nx, err_nx;
  logic       accept, code_legal;

  function automatic logic is_legal(input logic [7:0] c);
    logic [3:0] idx;
    idx = c[3:0];
    case (c[7:4])
      4'h0:    is_legal = (idx == 4'h0);
      4'h1:    is_legal = (idx >= 4'h1) && (idx <= 4'h5);
      4'h2:    is_legal = (idx >= 4'h1) && (idx <= 4'h9);
      4'h3:    is_legal = (idx >= 4'h1) && (idx <= 4'h6);
      4'h4:    is_legal = (idx >= 4'h1) && (idx <= 4'h6);
      default: is_legal = 1'b0;
    endcase
  endfunction

  assign req_ready  = ((state == IDLE) || (state == RUN)) && !abort;
  assign accept     = req_valid && req_ready;
  assign code_legal = is_legal(req_code);

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    count_nx   = count;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (accept) begin
          if (!code_legal) begin
            err_nx = 1'b1;
          end else if ((state == IDLE && req_code == 8'h00) ||
                       (state == RUN && req_code == select)) begin
            done_nx = 1'b1;
          end else begin
            // a 0x00 from RUN drains with pending=0 and then falls back to IDLE
            pending_nx = req_code;
            count_nx   = CNT_LOAD;
            state_nx   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (count == 8'd0) begin
          if (pending == 8'h00) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = SETTLE;
            count_nx = CNT_LOAD;
          end
        end else begin
          count_nx = count - 8'd1;
        end
      end
      SETTLE: begin
        if (count == 8'd0) begin
          state_nx = RUN;
          done_nx  = 1'b1;
        end else begin
          count_nx = count - 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx   = IDLE;
      pending_nx = 8'h00;
      count_nx   = 8'd0;
      done_nx    = 1'b0;
      err_nx     = 1'b0;
    end
    select_nx = ((state_nx == SETTLE) || (state_nx == RUN)) ? pending_nx : 8'h00;
    active_nx = (state_nx == RUN);
    busy_nx   = (state_nx == DRAIN) || (state_nx == SETTLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 8'h00;
      count   <= 8'd0;
      select  <= 8'h00;
      active  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      count   <= count_nx;
      select  <= select_nx;
      active  <= active_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_expe_sched.sv
// Self-checking bench for expe_sched with SETTLE_CYC=4: directed scenarios plus random
// request streams compared against a cycle-trace reference model.
module tb_expe_sched;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_code = 8'h00;
  logic       abort = 1'b0;
  logic [7:0] select;
  logic       active, busy, done, err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] m_sel = 8'h00;
  logic       m_run = 1'b0;
  logic [7:0] legal_q[$];

  expe_sched #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_code(req_code), .abort(abort), .select(select), .active(active),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic bit ref_legal(input logic [7:0] c);
    return (c == 8'h00) || (c >= 8'h11 && c <= 8'h15) || (c >= 8'h21 && c <= 8'h29) ||
           (c >= 8'h31 && c <= 8'h36) || (c >= 8'h41 && c <= 8'h46);
  endfunction

  // issue one request and check every following cycle against the expected trace
  task automatic run_request(input logic [7:0] c, input string name);
    int kind, n;
    logic [12:0] exp_v, got_v;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL %s ready_before got=%b required=1", name, req_ready);
    else pass_cnt++;
    req_valid = 1'b1;
    req_code  = c;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_code = 8'($urandom);
    if (!ref_legal(c)) kind = 0;
    else if ((!m_run && c == 8'h00) || (m_run && c == m_sel)) kind = 1;
    else if (c == 8'h00) kind = 2;
    else kind = 3;
    n = (kind == 3) ? 2*S + 2 : (kind == 2) ? S + 2 : 2;
    for (int k = 1; k <= n; k++) begin
      exp_v = {m_sel, m_run, 1'b0, 1'b0, 1'b0, 1'b1};
      if (kind == 0 && k == 1) exp_v = {m_sel, m_run, 1'b0, 1'b0, 1'b1, 1'b1};
      if (kind == 1 && k == 1) exp_v = {m_sel, m_run, 1'b0, 1'b1, 1'b0, 1'b1};
      if (kind == 2) begin
        if (k <= S)          exp_v = {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        else if (k == S + 1) exp_v = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        else                 exp_v = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      end
      if (kind == 3) begin
        if (k <= S)            exp_v = {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        else if (k <= 2*S)     exp_v = {c,     1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        else if (k == 2*S + 1) exp_v = {c,     1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        else                   exp_v = {c,     1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      end
      @(negedge clk);
      got_v = {select, active, busy, done, err, req_ready};
      total_cnt++;
      if (got_v !== exp_v)
        $display("FAIL %s code=%h cycle=%0d got{sel,act,busy,done,err,rdy}=%h required=%h",
                 name, c, k, got_v, exp_v);
      else pass_cnt++;
    end
    if (kind == 2) begin m_sel = 8'h00; m_run = 1'b0; end
    if (kind == 3) begin m_sel = c; m_run = 1'b1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({select, active, busy, done, err, req_ready} !== {8'h00, 5'b00001})
      $display("FAIL reset got=%h required=%h",
               {select, active, busy, done, err, req_ready}, {8'h00, 5'b00001});
    else pass_cnt++;
    rst_n = 1'b1;
    m_sel = 8'h00;
    m_run = 1'b0;
  endtask

  task automatic test_switch();
    run_request(8'h23, "switch_from_idle");
    run_request(8'h41, "switch_from_run");
  endtask

  task automatic test_illegal();
    logic [7:0] bad[4] = '{8'h16, 8'h2A, 8'h50, 8'h0F};
    for (int i = 0; i < 4; i++) run_request(bad[i], "illegal");
  endtask

  task automatic test_same_and_deselect();
    run_request(8'h35, "switch_to_35");
    run_request(8'h35, "same_code");
    run_request(8'h00, "deselect");
    run_request(8'h00, "deselect_idle");
  endtask

  task automatic test_abort();
    @(negedge clk);
    req_valid = 1'b1;
    req_code  = 8'h23;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (S + 1) @(posedge clk);
    #1 abort = 1'b1;
    req_valid = 1'b1;
    req_code  = 8'h15;
    @(negedge clk);
    total_cnt++;
    if ({select, busy, req_ready} !== {8'h23, 1'b1, 1'b0})
      $display("FAIL abort_pre got=%h required=%h", {select, busy, req_ready}, {8'h23, 2'b10});
    else pass_cnt++;
    @(posedge clk);
    #1 abort = 1'b0;
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({select, active, busy, done, err, req_ready} !== {8'h00, 5'b00001})
        $display("FAIL abort_post cycle=%0d got=%h required=%h", k,
                 {select, active, busy, done, err, req_ready}, {8'h00, 5'b00001});
      else pass_cnt++;
    end
    m_sel = 8'h00;
    m_run = 1'b0;
    run_request(8'h12, "after_abort");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_code  = 8'h32;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({select, active, busy, done, err, req_ready} !== {8'h00, 5'b00001})
      $display("FAIL async_reset got=%h required=%h",
               {select, active, busy, done, err, req_ready}, {8'h00, 5'b00001});
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_sel = 8'h00;
    m_run = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({select, active, busy, done} !== 11'h000)
        $display("FAIL post_reset_idle cycle=%0d got=%h required=000", k,
                 {select, active, busy, done});
      else pass_cnt++;
    end
    run_request(8'h11, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] c;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    c = legal_q[$urandom_range(0, legal_q.size() - 1)];
        2:       c = 8'($urandom);
        3:       c = 8'h00;
        default: c = m_sel;
      endcase
      run_request(c, "random");
    end
  endtask

  initial begin
    for (int v = 0; v < 256; v++)
      if (ref_legal(8'(v))) legal_q.push_back(8'(v));
    test_reset();
    test_switch();
    test_illegal();
    test_same_and_deselect();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
